// File: rtl/adder_acc_pkg.sv
// Shared definitions for the adder result accumulator: FSM states and
// the fixed widths of the incoming adder result and the item counter.
package adder_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int SUM_W = 9;
  localparam int CNT_W = 8;

endpackage

// File: rtl/adder_result_accumulator.sv
// Sums blocks of N_ACC 9-bit adder results into an ACC_W-bit total and
// presents total, count and sticky overflow on a registered valid/ready port.
module adder_result_accumulator
  import adder_acc_pkg::*;
#(
  parameter int N_ACC = 4,
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_carry,
  input  logic [7:0]       in_sum,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  generate
    if (N_ACC < 1 || N_ACC > 255 || ACC_W < SUM_W) begin : g_bad_params
      $error("adder_result_accumulator: N_ACC must be 1..255 and ACC_W >= 9");
    end
  endgenerate

  // Handshake: a transfer occurs on a rising edge where valid && ready;
  // ready/valid here depend only on the state register, never on inputs.

  state_t           state, state_next;
  logic [ACC_W-1:0] total, total_next;
  logic [CNT_W-1:0] count, count_next;
  logic             ovf, ovf_next;

  logic [ACC_W-1:0] operand;
  logic [ACC_W:0]   add_ext;
  logic [CNT_W-1:0] count_inc;
  logic             take;

  assign operand   = ACC_W'({in_carry, in_sum});
  assign add_ext   = {1'b0, total} + {1'b0, operand};
  assign count_inc = count + CNT_W'(1);

  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign take      = in_valid && in_ready;

  assign out_total = total;
  assign out_count = count;
  assign out_ovf   = ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      total <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_next;
      total <= total_next;
      count <= count_next;
      ovf   <= ovf_next;
    end
  end

  always_comb begin
    state_next = state;
    total_next = total;
    count_next = count;
    ovf_next   = ovf;
    case (state)
      IDLE: begin
        // An empty block is never emitted, so flush has no effect here.
        if (take) begin
          total_next = operand;
          count_next = CNT_W'(1);
          ovf_next   = 1'b0;
          state_next = (N_ACC == 1) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (take) begin
          total_next = add_ext[ACC_W-1:0];
          count_next = count_inc;
          ovf_next   = ovf | add_ext[ACC_W];
          if (count_inc == CNT_W'(N_ACC) || flush) state_next = HOLD;
        end else if (flush) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_adder_result_accumulator.sv
// Directed bench for adder_result_accumulator: default, ACC_W=10 and
// N_ACC=1 instances sharing clock, reset and result data.
module tb_adder_result_accumulator;

  logic       clk;
  logic       rst_n;
  logic       in_carry;
  logic [7:0] in_sum;

  logic        v0, rdy0, f0, ov0, or0, ovf0;
  logic [11:0] tot0;
  logic [7:0]  cnt0;

  logic        v1, rdy1, f1, ov1, or1, ovf1;
  logic [9:0]  tot1;
  logic [7:0]  cnt1;

  logic        v2, rdy2, f2, ov2, or2, ovf2;
  logic [11:0] tot2;
  logic [7:0]  cnt2;

  int errors;
  int checks;

  adder_result_accumulator dut (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(rdy0),
    .in_carry(in_carry), .in_sum(in_sum), .flush(f0),
    .out_valid(ov0), .out_ready(or0), .out_total(tot0),
    .out_count(cnt0), .out_ovf(ovf0)
  );

  adder_result_accumulator #(.N_ACC(4), .ACC_W(10)) dut_w10 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1),
    .in_carry(in_carry), .in_sum(in_sum), .flush(f1),
    .out_valid(ov1), .out_ready(or1), .out_total(tot1),
    .out_count(cnt1), .out_ovf(ovf1)
  );

  adder_result_accumulator #(.N_ACC(1), .ACC_W(12)) dut_n1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2),
    .in_carry(in_carry), .in_sum(in_sum), .flush(f2),
    .out_valid(ov2), .out_ready(or2), .out_total(tot2),
    .out_count(cnt2), .out_ovf(ovf2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [8:0] v);
    {in_carry, in_sum} = v;
  endtask

  task automatic check_out0(input string tag, input logic valid, input logic [11:0] tot,
                            input logic [7:0] cnt, input logic ovf);
    check({tag, ".valid"}, 32'(ov0), 32'(valid));
    check({tag, ".ready"}, 32'(rdy0), 32'(!valid));
    check({tag, ".total"}, 32'(tot0), 32'(tot));
    check({tag, ".count"}, 32'(cnt0), 32'(cnt));
    check({tag, ".ovf"},   32'(ovf0), 32'(ovf));
  endtask

  // feed a list of results to dut back-to-back
  task automatic feed0(input logic [8:0] a, input logic [8:0] b,
                       input logic [8:0] c, input logic [8:0] d, input int n);
    logic [8:0] vals [4];
    vals[0] = a; vals[1] = b; vals[2] = c; vals[3] = d;
    for (int i = 0; i < n; i++) begin
      v0 = 1'b1;
      set_data(vals[i]);
      tick();
    end
    v0 = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    {v0, f0, or0, v1, f1, or1, v2, f2, or2} = '0;
    set_data(9'h000);
    #12;
    check_out0("reset", 1'b0, 12'h000, 8'd0, 1'b0);
    check("reset.w10_ready", 32'(rdy1), 32'd1);
    check("reset.n1_valid", 32'(ov2), 32'd0);
    rst_n = 1'b1;
    tick();

    // Full block: 0x0FF+0x1FE+0x001+0x100 = 0x3FE
    or0 = 1'b1;
    feed0(9'h0FF, 9'h1FE, 9'h001, 9'h100, 3);
    check("full.partial_valid", 32'(ov0), 32'd0);
    check("full.partial_count", 32'(cnt0), 32'd3);
    v0 = 1'b1; set_data(9'h100); tick();
    check_out0("full", 1'b1, 12'h3FE, 8'd4, 1'b0);
    // bubble: item offered during HOLD must not be taken
    set_data(9'h007); tick();
    check("bubble.valid", 32'(ov0), 32'd0);
    check("bubble.ready", 32'(rdy0), 32'd1);
    check("bubble.count_unchanged", 32'(cnt0), 32'd4);
    tick();
    check("bubble.next_first_count", 32'(cnt0), 32'd1);
    check("bubble.next_first_total", 32'(tot0), 32'h007);
    v0 = 1'b0; f0 = 1'b1; tick(); f0 = 1'b0;
    check_out0("flush_single", 1'b1, 12'h007, 8'd1, 1'b0);
    tick();
    check("flush_single.drain", 32'(ov0), 32'd0);

    // Early flush without a transfer
    feed0(9'h010, 9'h020, 9'h000, 9'h000, 2);
    or0 = 1'b0; f0 = 1'b1; tick(); f0 = 1'b0;
    check_out0("flush_idle_in", 1'b1, 12'h030, 8'd2, 1'b0);
    or0 = 1'b1; tick(); or0 = 1'b0;
    // Flush together with a transfer
    feed0(9'h001, 9'h000, 9'h000, 9'h000, 1);
    v0 = 1'b1; f0 = 1'b1; set_data(9'h005); tick();
    v0 = 1'b0; f0 = 1'b0;
    check_out0("flush_with_item", 1'b1, 12'h006, 8'd2, 1'b0);
    or0 = 1'b1; tick();
    check("flush_with_item.drain", 32'(ov0), 32'd0);

    // Back-pressure for 10 cycles, with an input still offered
    or0 = 1'b0;
    feed0(9'h001, 9'h001, 9'h001, 9'h001, 4);
    v0 = 1'b1; set_data(9'h0AA);
    for (int i = 0; i < 10; i++) begin
      check_out0($sformatf("bp%0d", i), 1'b1, 12'h004, 8'd4, 1'b0);
      tick();
    end
    v0 = 1'b0; or0 = 1'b1; tick();
    check("bp.release_valid", 32'(ov0), 32'd0);
    check("bp.release_ready", 32'(rdy0), 32'd1);

    // Flush in IDLE emits nothing
    f0 = 1'b1; tick(); f0 = 1'b0;
    check("idle_flush.valid", 32'(ov0), 32'd0);
    tick();
    check("idle_flush.valid_later", 32'(ov0), 32'd0);
    check("idle_flush.ready", 32'(rdy0), 32'd1);

    // Overflow with ACC_W=10: 4 x 0x1FF = 0x7FC -> 0x3FC, carry out
    or1 = 1'b0; v1 = 1'b1; set_data(9'h1FF);
    for (int i = 0; i < 4; i++) tick();
    v1 = 1'b0;
    check("w10.valid", 32'(ov1), 32'd1);
    check("w10.total", 32'(tot1), 32'h3FC);
    check("w10.count", 32'(cnt1), 32'd4);
    check("w10.ovf",   32'(ovf1), 32'd1);
    or1 = 1'b1; tick();
    check("w10.drain", 32'(ov1), 32'd0);

    // N_ACC=1 emits each item
    or2 = 1'b0; v2 = 1'b1; set_data(9'h1AB); tick(); v2 = 1'b0;
    check("n1.valid", 32'(ov2), 32'd1);
    check("n1.ready", 32'(rdy2), 32'd0);
    check("n1.total", 32'(tot2), 32'h1AB);
    check("n1.count", 32'(cnt2), 32'd1);
    or2 = 1'b1; tick();
    check("n1.drain", 32'(ov2), 32'd0);

    // Asynchronous reset mid-block
    or0 = 1'b1;
    feed0(9'h001, 9'h001, 9'h000, 9'h000, 2);
    check("mid.count_before", 32'(cnt0), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check_out0("mid_reset", 1'b0, 12'h000, 8'd0, 1'b0);
    #2 rst_n = 1'b1;
    tick();
    or0 = 1'b0;
    feed0(9'h001, 9'h001, 9'h001, 9'h001, 4);
    check_out0("after_reset", 1'b1, 12'h004, 8'd4, 1'b0);
    or0 = 1'b1; tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
